// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one memory port between icache refills and dcache refills/writebacks.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed dcache priority.
module mem_refill_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ic_req_valid,
  input  logic [ADDR_W-1:0]        ic_req_addr,
  output logic                     ic_req_ready,
  output logic                     ic_resp_valid,
  output logic [$clog2(BEATS)-1:0] ic_resp_beat,
  output logic [DATA_W-1:0]        ic_resp_data,
  input  logic                     dc_req_valid,
  input  logic                     dc_req_rnw,
  input  logic [ADDR_W-1:0]        dc_req_addr,
  input  logic [DATA_W-1:0]        dc_req_wdata,
  output logic                     dc_req_ready,
  output logic                     dc_resp_valid,
  output logic [$clog2(BEATS)-1:0] dc_resp_beat,
  output logic [DATA_W-1:0]        dc_resp_data,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_rnw,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [DATA_W-1:0]        mem_req_data,
  input  logic                     mem_resp_valid,
  input  logic [DATA_W-1:0]        mem_resp_data,
  output logic                     busy
);
  localparam int BW = $clog2(BEATS);
  localparam int OFF = $clog2(BEATS * DATA_W / 8);
  localparam int BSH = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR_DATA} state_t;
  state_t state, state_n;
  logic grant_dc, grant_dc_n, pick_dc, any_req, rd_beat;
  logic [ADDR_W-1:0] base, base_n, req_addr;
  logic [BW-1:0] beat, beat_n;
  assign any_req = ic_req_valid | dc_req_valid;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_dc;
  // On a tie, the requester that did not win last time goes first.
  assign pick_dc = dc_req_valid & (~ic_req_valid | ~last_dc);
  always_ff @(posedge clk)
    if (reset) last_dc <= 1'b0;
    else if (state == IDLE && any_req) last_dc <= pick_dc;
`else
  assign pick_dc = dc_req_valid;
`endif
  assign req_addr = pick_dc ? dc_req_addr : ic_req_addr;
  always_comb begin
    state_n = state;
    grant_dc_n = grant_dc;
    base_n = base;
    beat_n = beat;
    case (state)
      IDLE: if (any_req) begin
        grant_dc_n = pick_dc;
        base_n = req_addr & LINE_MASK;
        beat_n = '0;
        state_n = (pick_dc && !dc_req_rnw) ? WR_DATA : RD_ADDR;
      end
      RD_ADDR: if (mem_req_ready) begin
        beat_n = '0;
        state_n = RD_DATA;
      end
      RD_DATA: if (mem_resp_valid) begin
        beat_n = beat + 1'b1;
        state_n = (beat == LAST) ? IDLE : RD_DATA;
      end
      WR_DATA: if (mem_req_ready) begin
        beat_n = beat + 1'b1;
        state_n = (beat == LAST) ? IDLE : WR_DATA;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      grant_dc <= 1'b0;
      base <= '0;
      beat <= '0;
    end else begin
      state <= state_n;
      grant_dc <= grant_dc_n;
      base <= base_n;
      beat <= beat_n;
    end
  assign busy = state != IDLE;
  assign mem_req_valid = (state == RD_ADDR) || (state == WR_DATA);
  assign mem_req_rnw = state == RD_ADDR;
  assign mem_req_addr = (state == RD_ADDR) ? base :
                        (state == WR_DATA) ? base + (ADDR_W'(beat) << BSH) : '0;
  assign mem_req_data = (state == WR_DATA) ? dc_req_wdata : '0;
  assign ic_req_ready = (state == RD_ADDR) && mem_req_ready && !grant_dc;
  assign dc_req_ready = mem_req_valid && mem_req_ready && grant_dc;
  // Response beats pass straight through; anything outside RD_DATA is dropped.
  assign rd_beat = (state == RD_DATA) && mem_resp_valid;
  assign ic_resp_valid = rd_beat && !grant_dc;
  assign dc_resp_valid = rd_beat && grant_dc;
  assign ic_resp_beat = ic_resp_valid ? beat : '0;
  assign dc_resp_beat = dc_resp_valid ? beat : '0;
  assign ic_resp_data = ic_resp_valid ? mem_resp_data : '0;
  assign dc_resp_data = dc_resp_valid ? mem_resp_data : '0;
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: scoreboard bench for mem_refill_arbiter with a simple memory and requester model.
module tb_mem_refill_arbiter;
  localparam int BEATS = 4;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic ic_req_valid, ic_req_ready, ic_resp_valid, dc_req_valid, dc_req_rnw, dc_req_ready, dc_resp_valid;
  logic [31:0] ic_req_addr, dc_req_addr, mem_req_addr;
  logic [127:0] ic_resp_data, dc_resp_data, dc_req_wdata, mem_req_data, mem_resp_data;
  logic [1:0] ic_resp_beat, dc_resp_beat;
  logic mem_req_valid, mem_req_ready, mem_req_rnw, mem_resp_valid, busy;
  mem_refill_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_beat(ic_resp_beat), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_rnw(dc_req_rnw), .dc_req_addr(dc_req_addr),
    .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_beat(dc_resp_beat), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
  );
  int checks = 0, errors = 0;
  logic [162:0] exp_mem[$];
  logic [129:0] exp_ic[$], exp_dc[$];
  int pend = 0, ri = 0, wb = 0, stall_at = -1, stall_len = 0, stall_left = 0, dc_reissue = 0, dc_pulses = 0;
  logic [31:0] rbase = '0, dc_next_addr = '0;
  logic spurious = 0;
  function automatic logic [127:0] mem_data(logic [31:0] a, int i);
    return {a, 32'(i), 32'hA5A5_0000, 32'h0BAD_F00D ^ a};
  endfunction
  function automatic logic [127:0] wdat(int i);
    return {96'hFEED_FACE_CAFE_BEEF_1234_5678, 32'(i)};
  endfunction
  task automatic chk(input string nm, input logic [162:0] a, input logic [162:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, a, e);
    end
  endtask
  task automatic push_mem(input logic icr, input logic dcr, input logic rnw, input logic [31:0] a, input logic [127:0] d);
    exp_mem.push_back({icr, dcr, rnw, a, d});
  endtask
  task automatic push_line(input logic dc, input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++)
      if (dc) exp_dc.push_back({2'(i), mem_data(b, i)});
      else exp_ic.push_back({2'(i), mem_data(b, i)});
  endtask
  // Scoreboard monitor: every presented output pops one expected entry.
  always @(negedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      if (exp_mem.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_req unexpected got addr %h rnw %b", mem_req_addr, mem_req_rnw);
      end else chk("mem_req", {ic_req_ready, dc_req_ready, mem_req_rnw, mem_req_addr, mem_req_data}, exp_mem.pop_front());
    end
    if (ic_resp_valid) begin
      if (exp_ic.size() == 0) begin
        checks++; errors++;
        $display("FAIL ic_resp unexpected got beat %0d data %h", ic_resp_beat, ic_resp_data);
      end else chk("ic_resp", 163'({ic_resp_beat, ic_resp_data}), 163'(exp_ic.pop_front()));
    end
    if (dc_resp_valid) begin
      if (exp_dc.size() == 0) begin
        checks++; errors++;
        $display("FAIL dc_resp unexpected got beat %0d data %h", dc_resp_beat, dc_resp_data);
      end else chk("dc_resp", 163'({dc_resp_beat, dc_resp_data}), 163'(exp_dc.pop_front()));
    end
  end
  // One clock of requester and memory behaviour; inputs change 1 time unit after the edge.
  task automatic tick();
    logic icf, dcf, rdf, rsp;
    logic [31:0] a;
    @(negedge clk);
    icf = ic_req_ready;
    dcf = dc_req_ready;
    rdf = mem_req_valid && mem_req_ready && mem_req_rnw;
    a = mem_req_addr;
    rsp = mem_resp_valid && pend > 0;
    @(posedge clk); #1;
    if (rsp) begin ri++; pend--; end
    if (rdf) begin pend = BEATS; rbase = a; ri = 0; end
    mem_resp_valid = pend > 0 || spurious;
    mem_resp_data = pend > 0 ? mem_data(rbase, ri) : 128'hDEAD;
    if (icf) ic_req_valid = 0;
    if (dcf) begin
      if (dc_req_rnw) begin
        if (dc_reissue > 0) begin dc_reissue--; dc_req_addr = dc_next_addr; end
        else dc_req_valid = 0;
      end else begin
        wb++; dc_pulses++;
        if (wb == BEATS) begin dc_req_valid = 0; wb = 0; end
        else dc_req_wdata = wdat(wb);
        if (wb == stall_at) stall_left = stall_len;
      end
    end
    mem_req_ready = stall_left == 0;
    if (stall_left > 0) stall_left--;
  endtask
  function automatic logic done();
    return exp_mem.size() == 0 && exp_ic.size() == 0 && exp_dc.size() == 0 && !busy && !ic_req_valid && !dc_req_valid;
  endfunction
  task automatic wait_done(input string nm);
    int n = 0;
    while (!done() && n < 200) begin tick(); n++; end
    checks++;
    if (!done()) begin
      errors++;
      $display("FAIL %s timeout got busy %b mem_q %0d ic_q %0d dc_q %0d required idle and empty", nm, busy, exp_mem.size(), exp_ic.size(), exp_dc.size());
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200000");
    $fatal(1);
  end
  initial begin
    ic_req_valid = 0; ic_req_addr = 0; dc_req_valid = 0; dc_req_rnw = 1; dc_req_addr = 0; dc_req_wdata = 0;
    mem_req_ready = 1; mem_resp_valid = 0; mem_resp_data = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_req_addr, 0);
    chk("rst_readies", {ic_req_ready, dc_req_ready}, 0);
    chk("rst_resp_valid", {ic_resp_valid, dc_resp_valid}, 0);
    reset = 0;
    tick();
    // icache line read: base cleared to line, request issued the cycle after grant
    push_mem(1, 0, 1, 32'h1000_0000, 0);
    push_line(0, 32'h1000_0000, 4);
    ic_req_valid = 1; ic_req_addr = 32'h1000_0024;
    chk("ic_pre_busy", busy, 0);
    chk("ic_pre_mem_valid", mem_req_valid, 0);
    tick();
    chk("ic_mem_valid", mem_req_valid, 1);
    chk("ic_mem_addr", mem_req_addr, 32'h1000_0000);
    chk("ic_busy", busy, 1);
    wait_done("ic_read");
    chk("ic_busy_drop", busy, 0);
    // dcache writeback with a 2-cycle stall on beat 1 and spurious response beats
    for (int i = 0; i < 4; i++) push_mem(0, 1, 0, 32'h2000_0040 + 32'(16 * i), wdat(i));
    dc_pulses = 0; stall_at = 1; stall_len = 2; spurious = 1;
    dc_req_valid = 1; dc_req_rnw = 0; dc_req_addr = 32'h2000_0040; dc_req_wdata = wdat(0);
    wait_done("dc_write");
    chk("dc_write_pulses", 32'(dc_pulses), 4);
    spurious = 0; stall_at = -1;
    tick();
    // spurious response in IDLE
    mem_resp_valid = 1; mem_resp_data = 128'h1234;
    #1;
    chk("idle_spurious", {ic_resp_valid, dc_resp_valid}, 0);
    tick();
    // simultaneous reads from a fresh reset; dcache re-requests while icache waits
    reset = 1; tick(); tick(); reset = 0;
`ifdef ARB_ROUND_ROBIN_EN
    push_mem(0, 1, 1, 32'h4000_0080, 0);
    push_mem(1, 0, 1, 32'h3000_0000, 0);
    push_mem(0, 1, 1, 32'h5000_0000, 0);
`else
    push_mem(0, 1, 1, 32'h4000_0080, 0);
    push_mem(0, 1, 1, 32'h5000_0000, 0);
    push_mem(1, 0, 1, 32'h3000_0000, 0);
`endif
    push_line(1, 32'h4000_0080, 4);
    push_line(1, 32'h5000_0000, 4);
    push_line(0, 32'h3000_0000, 4);
    dc_reissue = 1; dc_next_addr = 32'h5000_0000;
    ic_req_valid = 1; ic_req_addr = 32'h3000_0010;
    dc_req_valid = 1; dc_req_rnw = 1; dc_req_addr = 32'h4000_0088;
    wait_done("arbitration");
    // reset during beat 2 of an icache refill
    push_mem(1, 0, 1, 32'h6000_0000, 0);
    push_line(0, 32'h6000_0000, 3);
    ic_req_valid = 1; ic_req_addr = 32'h6000_0008;
    begin
      int n = 0;
      while (!(pend > 0 && ri == 2) && n < 50) begin tick(); n++; end
      checks++;
      if (!(pend > 0 && ri == 2)) begin
        errors++;
        $display("FAIL reset_setup timeout got beat %0d required 2", ri);
      end
    end
    reset = 1; tick(); reset = 0;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_late_beat", {ic_resp_valid, dc_resp_valid}, 0);
    tick();
    push_mem(1, 0, 1, 32'h6000_0040, 0);
    push_line(0, 32'h6000_0040, 4);
    ic_req_valid = 1; ic_req_addr = 32'h6000_0040;
    wait_done("after_reset_read");
    chk("final_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
